// File: rtl/cache_miss_handler_if.sv
// Signal bundle between the miss handler and its neighbours: requester, cache_lru,
// tag/data arrays and memory. The handler drives through the master modport.
`ifndef ICACHE_NUM_SET
`define ICACHE_NUM_SET 4
`endif
`ifndef ICACHE_WAYS_PER_SET
`define ICACHE_WAYS_PER_SET 4
`endif

interface cache_miss_handler_if #(
  parameter int ADDR_W       = 32,
  parameter int LINE_BYTES   = 16,
  parameter int NUM_SET      = `ICACHE_NUM_SET,
  parameter int WAYS_PER_SET = `ICACHE_WAYS_PER_SET
);
  localparam int LINE_W         = 8 * LINE_BYTES;
  localparam int NUM_SET_W      = $clog2(NUM_SET);
  localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET);
  localparam int OFF_W          = $clog2(LINE_BYTES);
  localparam int TAG_W          = ADDR_W - NUM_SET_W - OFF_W;

  // Handshakes: miss_req is held by the requester and taken on a clock edge where
  // miss_busy is low. mem_req/mem_we/mem_addr/mem_wdata stay stable until the edge
  // that samples mem_rsp_valid high; that edge completes the transfer.
  logic                      miss_req;
  logic [ADDR_W-1:0]         miss_addr;
  logic                      miss_busy;
  logic                      miss_done;

  logic                      victim_req;
  logic [NUM_SET_W-1:0]      victim_set;
  logic [WAYS_PER_SET_W-1:0] victim_way;
  logic                      vic_valid;
  logic                      vic_dirty;
  logic [TAG_W-1:0]          vic_tag;
  logic [LINE_W-1:0]         vic_data;

  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [LINE_W-1:0]         mem_wdata;
  logic                      mem_rsp_valid;
  logic [LINE_W-1:0]         mem_rsp_data;

  logic                      fill_valid;
  logic [NUM_SET_W-1:0]      fill_set;
  logic [WAYS_PER_SET_W-1:0] fill_way;
  logic [TAG_W-1:0]          fill_tag;
  logic [LINE_W-1:0]         fill_data;
  logic                      update_req;
  logic [NUM_SET_W-1:0]      update_set;
  logic [WAYS_PER_SET_W-1:0] update_way;

  modport master (
    input  miss_req, miss_addr, victim_way, vic_valid, vic_dirty, vic_tag, vic_data,
           mem_rsp_valid, mem_rsp_data,
    output miss_busy, miss_done, victim_req, victim_set, mem_req, mem_we, mem_addr,
           mem_wdata, fill_valid, fill_set, fill_way, fill_tag, fill_data,
           update_req, update_set, update_way
  );

  modport slave (
    output miss_req, miss_addr, victim_way, vic_valid, vic_dirty, vic_tag, vic_data,
           mem_rsp_valid, mem_rsp_data,
    input  miss_busy, miss_done, victim_req, victim_set, mem_req, mem_we, mem_addr,
           mem_wdata, fill_valid, fill_set, fill_way, fill_tag, fill_data,
           update_req, update_set, update_way
  );
endinterface

// File: rtl/cache_miss_handler.sv
// Single-outstanding miss engine: pick victim, write back if dirty, read the line,
// fill the arrays and update LRU. Every output is a register set with the state.
`ifndef ICACHE_NUM_SET
`define ICACHE_NUM_SET 4
`endif
`ifndef ICACHE_WAYS_PER_SET
`define ICACHE_WAYS_PER_SET 4
`endif

module cache_miss_handler #(
  parameter int ADDR_W       = 32,
  parameter int LINE_BYTES   = 16,
  parameter int NUM_SET      = `ICACHE_NUM_SET,
  parameter int WAYS_PER_SET = `ICACHE_WAYS_PER_SET
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_miss_handler_if.master  bus,
  output logic [2:0]            fsm_state
);
  localparam int LINE_W         = 8 * LINE_BYTES;
  localparam int NUM_SET_W      = $clog2(NUM_SET);
  localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET);
  localparam int OFF_W          = $clog2(LINE_BYTES);
  localparam int TAG_W          = ADDR_W - NUM_SET_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VICTIM = 3'd1,
    S_WB     = 3'd2,
    S_RD     = 3'd3,
    S_FILL   = 3'd4
  } state_t;

  state_t                    state;
  logic [TAG_W-1:0]          tag_q;
  logic [NUM_SET_W-1:0]      set_q;
  logic [WAYS_PER_SET_W-1:0] way_q;

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      tag_q          <= '0;
      set_q          <= '0;
      way_q          <= '0;
      bus.miss_busy  <= 1'b0;
      bus.miss_done  <= 1'b0;
      bus.victim_req <= 1'b0;
      bus.victim_set <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.fill_valid <= 1'b0;
      bus.fill_set   <= '0;
      bus.fill_way   <= '0;
      bus.fill_tag   <= '0;
      bus.fill_data  <= '0;
      bus.update_req <= 1'b0;
      bus.update_set <= '0;
      bus.update_way <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.miss_req) begin
            tag_q          <= bus.miss_addr[ADDR_W-1 -: TAG_W];
            set_q          <= bus.miss_addr[OFF_W +: NUM_SET_W];
            bus.victim_req <= 1'b1;
            bus.victim_set <= bus.miss_addr[OFF_W +: NUM_SET_W];
            bus.miss_busy  <= 1'b1;
            state          <= S_VICTIM;
          end
        end

        // cache_lru answers combinationally, so the victim is captured this cycle.
        S_VICTIM: begin
          way_q          <= bus.victim_way;
          bus.victim_req <= 1'b0;
          bus.victim_set <= '0;
          bus.mem_req    <= 1'b1;
          if (bus.vic_valid && bus.vic_dirty) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {bus.vic_tag, set_q, {OFF_W{1'b0}}};
            bus.mem_wdata <= bus.vic_data;
            state         <= S_WB;
          end else begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {tag_q, set_q, {OFF_W{1'b0}}};
            state         <= S_RD;
          end
        end

        // Writeback done: the read goes out on the very next cycle, mem_req stays high.
        S_WB: begin
          if (bus.mem_rsp_valid) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {tag_q, set_q, {OFF_W{1'b0}}};
            bus.mem_wdata <= '0;
            state         <= S_RD;
          end
        end

        S_RD: begin
          if (bus.mem_rsp_valid) begin
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.fill_valid <= 1'b1;
            bus.fill_set   <= set_q;
            bus.fill_way   <= way_q;
            bus.fill_tag   <= tag_q;
            bus.fill_data  <= bus.mem_rsp_data;
            bus.update_req <= 1'b1;
            bus.update_set <= set_q;
            bus.update_way <= way_q;
            bus.miss_done  <= 1'b1;
            state          <= S_FILL;
          end
        end

        S_FILL: begin
          bus.fill_valid <= 1'b0;
          bus.fill_set   <= '0;
          bus.fill_way   <= '0;
          bus.fill_tag   <= '0;
          bus.fill_data  <= '0;
          bus.update_req <= 1'b0;
          bus.update_set <= '0;
          bus.update_way <= '0;
          bus.miss_done  <= 1'b0;
          bus.miss_busy  <= 1'b0;
          state          <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: clean, dirty and valid-clean misses,
// back-to-back requests, reset mid-read and spurious memory responses.
module tb_cache_miss_handler;
  localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] D2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] VD = 128'hdead_beef_cafe_f00d_0bad_f00d_a5a5_5a5a;

  logic       clock;
  logic       reset;
  logic [2:0] fsm_state;
  int         checks;
  int         errors;

  cache_miss_handler_if #(.ADDR_W(32), .LINE_BYTES(16), .NUM_SET(4), .WAYS_PER_SET(4)) bus ();

  cache_miss_handler #(.ADDR_W(32), .LINE_BYTES(16), .NUM_SET(4), .WAYS_PER_SET(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // driver tasks
  task automatic idle_inputs();
    bus.miss_req      = 1'b0;
    bus.miss_addr     = '0;
    bus.victim_way    = '0;
    bus.vic_valid     = 1'b0;
    bus.vic_dirty     = 1'b0;
    bus.vic_tag       = '0;
    bus.vic_data      = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic start_miss(input logic [31:0] addr, input logic [1:0] way,
                            input logic valid, input logic dirty,
                            input logic [25:0] tag, input logic [127:0] data);
    bus.miss_req   = 1'b1;
    bus.miss_addr  = addr;
    bus.victim_way = way;
    bus.vic_valid  = valid;
    bus.vic_dirty  = dirty;
    bus.vic_tag    = tag;
    bus.vic_data   = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.miss_busy, bus.miss_done, bus.victim_req, bus.mem_req, bus.mem_we,
         bus.fill_valid, bus.update_req} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {bus.miss_busy, bus.miss_done, bus.victim_req,
               bus.mem_req, bus.mem_we, bus.fill_valid, bus.update_req});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.fill_data, bus.fill_tag, bus.victim_set} !== '0) begin
      errors++;
      $display("FAIL reset_data got %0h/%0h exp 0", bus.mem_addr, bus.fill_data);
    end
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %0d exp 0", fsm_state);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clean_miss();
    start_miss(32'h1234, 2'd2, 1'b0, 1'b0, 26'h0, '0);
    @(negedge clock);
    bus.miss_req = 1'b0;
    checks++;
    if ({bus.victim_req, bus.victim_set, bus.miss_busy, bus.mem_req, fsm_state} !== {1'b1, 2'd3, 1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL clean_victim got %b exp %b", {bus.victim_req, bus.victim_set, bus.miss_busy,
               bus.mem_req, fsm_state}, {1'b1, 2'd3, 1'b1, 1'b0, 3'd1});
    end
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.victim_req, bus.mem_addr} !== {3'b100, 32'h1230}) begin
      errors++;
      $display("FAIL clean_rd_req got %b addr %0h exp 100 addr 1230",
               {bus.mem_req, bus.mem_we, bus.victim_req}, bus.mem_addr);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.fill_valid} !== 2'b10) begin
      errors++;
      $display("FAIL clean_rd_hold got %b exp 10", {bus.mem_req, bus.fill_valid});
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    checks++;
    if ({bus.fill_valid, bus.update_req, bus.miss_done, bus.mem_req, bus.victim_req} !== 5'b11100) begin
      errors++;
      $display("FAIL clean_fill_ctrl got %b exp 11100", {bus.fill_valid, bus.update_req,
               bus.miss_done, bus.mem_req, bus.victim_req});
    end
    checks++;
    if ({bus.fill_set, bus.fill_way, bus.fill_tag, bus.update_set, bus.update_way} !==
        {2'd3, 2'd2, 26'h48, 2'd3, 2'd2}) begin
      errors++;
      $display("FAIL clean_fill_target got set %0d way %0d tag %0h exp 3 2 48",
               bus.fill_set, bus.fill_way, bus.fill_tag);
    end
    checks++;
    if (bus.fill_data !== D1) begin
      errors++;
      $display("FAIL clean_fill_data got %0h exp %0h", bus.fill_data, D1);
    end
    @(negedge clock);
    checks++;
    if ({bus.fill_valid, bus.update_req, bus.miss_done, bus.miss_busy, fsm_state} !== 7'b0) begin
      errors++;
      $display("FAIL clean_return got %b exp 0", {bus.fill_valid, bus.update_req,
               bus.miss_done, bus.miss_busy, fsm_state});
    end
  endtask

  task automatic test_dirty_miss();
    start_miss(32'h1234, 2'd2, 1'b1, 1'b1, 26'h7, VD);
    @(negedge clock);
    bus.miss_req = 1'b0;
    @(negedge clock);
    // victim inputs now change; the writeback must keep the latched line
    bus.vic_data = D2;
    bus.vic_tag  = 26'h3ff;
    checks++;
    if ({bus.mem_req, bus.mem_we, fsm_state, bus.mem_addr} !== {2'b11, 3'd2, 32'h1f0}) begin
      errors++;
      $display("FAIL dirty_wb_req got %b addr %0h exp 11 addr 1f0",
               {bus.mem_req, bus.mem_we}, bus.mem_addr);
    end
    @(negedge clock);
    checks++;
    if (bus.mem_wdata !== VD) begin
      errors++;
      $display("FAIL dirty_wb_data got %0h exp %0h", bus.mem_wdata, VD);
    end
    bus.mem_rsp_valid = 1'b1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, fsm_state, bus.mem_addr} !== {2'b10, 3'd3, 32'h1230}) begin
      errors++;
      $display("FAIL dirty_rd_req got %b st %0d addr %0h exp 10 st 3 addr 1230",
               {bus.mem_req, bus.mem_we}, fsm_state, bus.mem_addr);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D2;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.fill_valid, bus.fill_tag, bus.fill_way, bus.fill_data} !== {1'b1, 26'h48, 2'd2, D2}) begin
      errors++;
      $display("FAIL dirty_fill got v %b tag %0h data %0h exp 1 48 %0h",
               bus.fill_valid, bus.fill_tag, bus.fill_data, D2);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_valid_clean();
    start_miss(32'h1234, 2'd1, 1'b1, 1'b0, 26'h7, VD);
    @(negedge clock);
    bus.miss_req = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.mem_we, fsm_state, bus.mem_addr} !== {2'b10, 3'd3, 32'h1230}) begin
      errors++;
      $display("FAIL vclean_rd_req got %b st %0d addr %0h exp 10 st 3 addr 1230",
               {bus.mem_req, bus.mem_we}, fsm_state, bus.mem_addr);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.fill_valid, bus.fill_way, bus.update_way} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL vclean_fill got v %b way %0d exp 1 1", bus.fill_valid, bus.fill_way);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    start_miss(32'h1234, 2'd0, 1'b0, 1'b0, 26'h0, '0);
    @(negedge clock);
    bus.miss_addr = 32'habc0;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.miss_busy, bus.victim_req, bus.mem_req, fsm_state} !== {3'b101, 3'd3}) begin
        errors++;
        $display("FAIL b2b_wait%0d got %b exp 101011", i,
                 {bus.miss_busy, bus.victim_req, bus.mem_req, fsm_state});
      end
      @(negedge clock);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.fill_valid, bus.victim_req, bus.fill_tag} !== {2'b10, 26'h48}) begin
      errors++;
      $display("FAIL b2b_fill1 got %b tag %0h exp 10 tag 48",
               {bus.fill_valid, bus.victim_req}, bus.fill_tag);
    end
    @(negedge clock);
    checks++;
    if ({bus.miss_busy, bus.victim_req, fsm_state} !== 5'b0) begin
      errors++;
      $display("FAIL b2b_idle got %b exp 0", {bus.miss_busy, bus.victim_req, fsm_state});
    end
    @(negedge clock);
    bus.miss_req = 1'b0;
    checks++;
    if ({bus.victim_req, bus.victim_set, bus.miss_busy} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_accept2 got %b exp 1001", {bus.victim_req, bus.victim_set, bus.miss_busy});
    end
    @(negedge clock);
    checks++;
    if (bus.mem_addr !== 32'habc0) begin
      errors++;
      $display("FAIL b2b_rd2_addr got %0h exp abc0", bus.mem_addr);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D2;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.fill_valid, bus.fill_set, bus.fill_tag, bus.fill_data} !== {1'b1, 2'd0, 26'h2af, D2}) begin
      errors++;
      $display("FAIL b2b_fill2 got v %b set %0d tag %0h exp 1 0 2af",
               bus.fill_valid, bus.fill_set, bus.fill_tag);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    start_miss(32'h1234, 2'd3, 1'b0, 1'b0, 26'h0, '0);
    @(negedge clock);
    bus.miss_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got mem_req %b exp 1", bus.mem_req);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.mem_req, bus.miss_busy, bus.fill_valid, bus.update_req, fsm_state, bus.mem_addr} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got %b addr %0h exp 0", {bus.mem_req, bus.miss_busy,
               bus.fill_valid, bus.update_req, fsm_state}, bus.mem_addr);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bus.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus.fill_valid, bus.update_req, bus.miss_done, bus.mem_req, fsm_state} !== '0) begin
        errors++;
        $display("FAIL rstmid_late%0d got %b exp 0", i, {bus.fill_valid, bus.update_req,
                 bus.miss_done, bus.mem_req, fsm_state});
      end
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = VD;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.miss_busy, bus.victim_req, bus.mem_req, bus.fill_valid, bus.update_req, fsm_state} !== '0) begin
      errors++;
      $display("FAIL spur_idle got %b exp 0", {bus.miss_busy, bus.victim_req, bus.mem_req,
               bus.fill_valid, bus.update_req, fsm_state});
    end
    start_miss(32'h1234, 2'd2, 1'b0, 1'b0, 26'h0, '0);
    @(negedge clock);
    bus.miss_req      = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.fill_valid, fsm_state} !== {2'b10, 3'd3}) begin
      errors++;
      $display("FAIL spur_victim got %b exp 10011", {bus.mem_req, bus.fill_valid, fsm_state});
    end
    @(negedge clock);
    checks++;
    if ({bus.mem_req, bus.fill_valid, fsm_state} !== {2'b10, 3'd3}) begin
      errors++;
      $display("FAIL spur_rd_hold got %b exp 10011", {bus.mem_req, bus.fill_valid, fsm_state});
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = D1;
    @(negedge clock);
    bus.mem_rsp_valid = 1'b0;
    checks++;
    if ({bus.fill_valid, bus.fill_data} !== {1'b1, D1}) begin
      errors++;
      $display("FAIL spur_fill got v %b data %0h exp 1 %0h", bus.fill_valid, bus.fill_data, D1);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_valid_clean();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
